ysyx_22040895_ifu: RTL and testbench
====================================

Name: ysyx_22040895_ifu

Overview:
- Instruction fetch unit directly upstream of the decode/control unit: owns the PC, fetches 32-bit instructions over a valid/ready memory port and presents the instruction plus pre-sliced opcode/func3/func7 fields to decode.
- Consumes the core's redirect (jump_branch + target) at instruction retirement.
- One instruction in flight; one-entry output holding register.

Parameters:
- RESET_PC, 64'h8000_0000, PC value loaded on reset.
- ADDR_W, 64, PC/address width.
- INST_W, 32, instruction width (fixed; not for override).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset (low = reset)
- req_valid_o_ifu  out  1  fetch request valid
- req_ready_i_ifu  in  1  memory accepts request
- req_addr_o_ifu  out  ADDR_W  fetch address (word aligned)
- rsp_valid_i_ifu  in  1  fetch response valid (always accepted)
- rsp_data_i_ifu  in  32  fetched instruction
- rsp_err_i_ifu  in  1  bus error on fetch
- inst_valid_o_ifu  out  1  instruction available to decode
- inst_ready_i_ifu  in  1  core retires the presented instruction this cycle
- inst_o_ifu  out  32  held instruction
- pc_o_ifu  out  ADDR_W  PC of held instruction
- opcode_o_ifu  out  7  inst[6:0]
- func3_o_ifu  out  3  inst[14:12]
- func7_o_ifu  out  7  inst[31:25]
- fault_o_ifu  out  1  held instruction is a fetch fault (bus error or misaligned PC)
- jump_branch_i_ifu  in  1  redirect, sampled only on retire handshake
- dnpc_i_ifu  in  ADDR_W  redirect target

Behaviour:
- States: REQ, WAIT, HOLD. Encoding local.
- Reset (rst low, async): state=REQ, pc=RESET_PC, inst=32'h0000_0013 (nop), fault=0; req_valid_o=0 while rst low; inst_valid_o=0. All outputs combinational from state/registers; no output reset glitch beyond rst.
- REQ: req_valid_o=1, req_addr_o=pc. If pc[1:0]!=0: no request issued (req_valid_o=0), go HOLD with fault=1, inst=nop. On req_valid&req_ready -> WAIT.
- req_addr_o stable and req_valid_o held high until ready (no withdrawal).
- WAIT: req_valid_o=0. On rsp_valid: inst<=rsp_data, fault<=rsp_err -> HOLD. Response never accepted in the same cycle as request acceptance; rsp_valid outside WAIT is ignored.
- HOLD: inst_valid_o=1; inst/pc/fields stable. On inst_valid&inst_ready: pc<=jump_branch_i ? dnpc_i : pc+4 (ADDR_W wraparound, no carry out) -> REQ.
- jump_branch_i/dnpc_i ignored in all cycles without retire handshake.
- Minimum 3 cycles per instruction with zero-wait memory (REQ accept, WAIT response, HOLD retire).
- Fields always sliced from the held inst register; in REQ/WAIT they show the previous instruction (or nop after reset), inst_valid_o=0.
- Redirect to a misaligned target: takes effect, then fault path in REQ.
- Faulted instruction still needs inst_ready to leave HOLD; fault recovery is via redirect.
- Reset asserted in WAIT: any later response for the old request is dropped (state REQ).

Decomposition:
- Shared define file: RESET_PC value, NOP encoding (32'h00000013), opcode/func3/func7 field length macros (already shared with decode), state encoding constants.
- Optional sub-module ysyx_22040895_pc_reg: PC register with reset, +4 and redirect mux; everything else stays in ifu.

Test Plan:
- Reset release, zero-wait memory returning 0x00500093 at 0x80000000 -> first req_addr 0x80000000; inst_valid on third cycle; opcode 7'h13, func3 0, func7 0, pc_o 0x80000000.
- Retire without redirect -> next req_addr 0x80000004; req_ready held low 3 cycles -> req_valid and addr stable all 3 cycles.
- Retire with jump_branch=1, dnpc=0x80000100 -> next req_addr 0x80000100; jump_branch=1 asserted while inst_ready=0 -> no effect, PC unchanged.
- rsp_err=1 with data 0xDEADBEEF -> HOLD with fault=1, inst 0xDEADBEEF; redirect 0x80000002 on retire -> no request issued, fault=1, inst nop.
- inst_ready low 5 cycles in HOLD -> outputs stable, no new request; rsp_valid pulsed during HOLD -> ignored.
- rst low mid-WAIT, late rsp_valid after release -> discarded; fetch restarts at 0x80000000, wrap test: pc 0xFFFF_FFFF_FFFF_FFFC retire -> next 0x0.

Source files
------------

// File: rtl/ysyx_22040895_ifu_pkg.sv
// Shared IFU constants: reset PC, NOP encoding, decode field widths
// and fetch FSM state encodings; imported by the IFU files.
package ysyx_22040895_ifu_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;

    localparam int INST_W   = 32;
    localparam int OPCODE_W = 7;
    localparam int FUNC3_W  = 3;
    localparam int FUNC7_W  = 7;

    // addi x0, x0, 0
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    function automatic logic pc_misaligned(input logic [1:0] lsb);
        return |lsb;
    endfunction

endpackage

// File: rtl/ysyx_22040895_ifu_if.sv
// Instruction memory port: request (valid/ready/addr) and response
// (valid/data/err). master = IFU side, slave = memory side.
interface ysyx_22040895_ifu_if #(
    parameter int ADDR_W = 64
);
    import ysyx_22040895_ifu_pkg::*;

    logic              req_valid_o_ifu;
    logic              req_ready_i_ifu;
    logic [ADDR_W-1:0] req_addr_o_ifu;
    logic              rsp_valid_i_ifu;
    logic [INST_W-1:0] rsp_data_i_ifu;
    logic              rsp_err_i_ifu;

    modport master (
        output req_valid_o_ifu,
        output req_addr_o_ifu,
        input  req_ready_i_ifu,
        input  rsp_valid_i_ifu,
        input  rsp_data_i_ifu,
        input  rsp_err_i_ifu
    );

    modport slave (
        input  req_valid_o_ifu,
        input  req_addr_o_ifu,
        output req_ready_i_ifu,
        output rsp_valid_i_ifu,
        output rsp_data_i_ifu,
        output rsp_err_i_ifu
    );

endinterface

// File: rtl/ysyx_22040895_pc_reg.sv
// PC register: async active-low reset to RESET_PC; on retire loads
// redirect target or pc+4. Ports: clk, rst, retire_i, jump_i, dnpc_i, pc_o.
module ysyx_22040895_pc_reg #(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              retire_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] dnpc_i,
    output logic [ADDR_W-1:0] pc_o
);

    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;

    // pc+4 wraps naturally at ADDR_W bits
    always_comb begin
        pc_d = pc_q;
        if (retire_i) begin
            pc_d = jump_i ? dnpc_i
                          : pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/ysyx_22040895_ifu.sv
// Instruction fetch unit: REQ/WAIT/HOLD fetch FSM, one-entry output hold.
// Ports: clk, rst (async low), mem (memory port), inst_*/field/fault/redirect.
module ysyx_22040895_ifu
    import ysyx_22040895_ifu_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22040895_ifu_if.master   mem,
    output logic                  inst_valid_o_ifu,
    input  logic                  inst_ready_i_ifu,
    output logic [INST_W-1:0]     inst_o_ifu,
    output logic [ADDR_W-1:0]     pc_o_ifu,
    output logic [OPCODE_W-1:0]   opcode_o_ifu,
    output logic [FUNC3_W-1:0]    func3_o_ifu,
    output logic [FUNC7_W-1:0]    func7_o_ifu,
    output logic                  fault_o_ifu,
    input  logic                  jump_branch_i_ifu,
    input  logic [ADDR_W-1:0]     dnpc_i_ifu
);

    logic [1:0]        state_q, state_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] pc;
    logic              mis;
    logic              in_req;
    logic              in_hold;
    logic              retire;

    assign in_req  = (state_q == ST_REQ);
    assign in_hold = (state_q == ST_HOLD);
    assign mis     = pc_misaligned(pc[1:0]);
    assign retire  = in_hold & inst_ready_i_ifu;

    ysyx_22040895_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .rst      (rst),
        .retire_i (retire),
        .jump_i   (jump_branch_i_ifu),
        .dnpc_i   (dnpc_i_ifu),
        .pc_o     (pc)
    );

    // a misaligned PC never reaches the bus
    assign mem.req_valid_o_ifu = rst & in_req & ~mis;
    assign mem.req_addr_o_ifu  = pc;

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        case (state_q)
            ST_REQ: begin
                if (mis) begin
                    state_d = ST_HOLD;
                    inst_d  = NOP_INST;
                    fault_d = 1'b1;
                end else if (mem.req_ready_i_ifu) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem.rsp_valid_i_ifu) begin
                    state_d = ST_HOLD;
                    inst_d  = mem.rsp_data_i_ifu;
                    fault_d = mem.rsp_err_i_ifu;
                end
            end
            ST_HOLD: begin
                if (inst_ready_i_ifu) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REQ;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    assign inst_valid_o_ifu = in_hold;
    assign inst_o_ifu       = inst_q;
    assign pc_o_ifu         = pc;
    assign fault_o_ifu      = fault_q;
    assign opcode_o_ifu     = inst_q[6:0];
    assign func3_o_ifu      = inst_q[14:12];
    assign func7_o_ifu      = inst_q[31:25];

endmodule

// File: tb/tb_ysyx_22040895_ifu.sv
// Directed bench for ysyx_22040895_ifu: reset, fetch timing, stalls,
// redirects, faults, reset-in-WAIT and PC wraparound.
module tb_ysyx_22040895_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [63:0] pc;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [6:0]  func7;
    logic        fault;
    logic        jump;
    logic [63:0] dnpc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ysyx_22040895_ifu_if #(.ADDR_W(64)) mem_if ();

    ysyx_22040895_ifu dut (
        .clk               (clk),
        .rst               (rst),
        .mem               (mem_if),
        .inst_valid_o_ifu  (inst_valid),
        .inst_ready_i_ifu  (inst_ready),
        .inst_o_ifu        (inst),
        .pc_o_ifu          (pc),
        .opcode_o_ifu      (opcode),
        .func3_o_ifu       (func3),
        .func7_o_ifu       (func7),
        .fault_o_ifu       (fault),
        .jump_branch_i_ifu (jump),
        .dnpc_i_ifu        (dnpc)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] d, input logic e);
        mem_if.req_ready_i_ifu = 1'b1;
        step();
        mem_if.req_ready_i_ifu = 1'b0;
        mem_if.rsp_valid_i_ifu = 1'b1;
        mem_if.rsp_data_i_ifu  = d;
        mem_if.rsp_err_i_ifu   = e;
        step();
        mem_if.rsp_valid_i_ifu = 1'b0;
        mem_if.rsp_err_i_ifu   = 1'b0;
    endtask

    task automatic do_retire(input logic j, input logic [63:0] t);
        jump       = j;
        dnpc       = t;
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
        jump       = 1'b0;
        dnpc       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        mem_if.req_ready_i_ifu = 1'b0;
        mem_if.rsp_valid_i_ifu = 1'b0;
        mem_if.rsp_data_i_ifu  = '0;
        mem_if.rsp_err_i_ifu   = 1'b0;
        inst_ready = 1'b0;
        jump       = 1'b0;
        dnpc       = '0;
        step();
        step();
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL rst_req_valid got=%0h exp=0",
                     mem_if.req_valid_o_ifu);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_inst_valid got=%0h exp=0", inst_valid);
        end
        checks++;
        if (inst !== 32'h0000_0013) begin
            errors++;
            $display("FAIL rst_inst got=%h exp=00000013", inst);
        end
        checks++;
        if (pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL rst_pc got=%h exp=80000000", pc);
        end
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL rst_fault got=%0h exp=0", fault);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h8000_0000) begin
            errors++;
            $display("FAIL first_req got v=%0h a=%h exp v=1 a=80000000",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
        end
    endtask

    task automatic test_first_fetch();
        mem_if.req_ready_i_ifu = 1'b1;
        step();
        mem_if.req_ready_i_ifu = 1'b0;
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL wait_outs got rv=%0h iv=%0h exp rv=0 iv=0",
                     mem_if.req_valid_o_ifu, inst_valid);
        end
        mem_if.rsp_valid_i_ifu = 1'b1;
        mem_if.rsp_data_i_ifu  = 32'h0050_0093;
        step();
        mem_if.rsp_valid_i_ifu = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || inst !== 32'h0050_0093) begin
            errors++;
            $display("FAIL first_inst got v=%0h i=%h exp v=1 i=00500093",
                     inst_valid, inst);
        end
        checks++;
        if (opcode !== 7'h13 || func3 !== 3'd0 || func7 !== 7'd0) begin
            errors++;
            $display("FAIL first_fields got %h/%h/%h exp 13/0/0",
                     opcode, func3, func7);
        end
        checks++;
        if (pc !== 64'h8000_0000 || fault !== 1'b0) begin
            errors++;
            $display("FAIL first_pc got pc=%h f=%0h exp 80000000/0",
                     pc, fault);
        end
    endtask

    task automatic test_seq_stall();
        do_retire(1'b0, 64'h0);
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h8000_0004 ||
            inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_req got v=%0h a=%h iv=%0h exp 1/80000004/0",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu,
                     inst_valid);
        end
        checks++;
        if (opcode !== 7'h13 || inst !== 32'h0050_0093) begin
            errors++;
            $display("FAIL prev_fields got op=%h i=%h exp 13/00500093",
                     opcode, inst);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (mem_if.req_valid_o_ifu !== 1'b1 ||
                mem_if.req_addr_o_ifu !== 64'h8000_0004) begin
                errors++;
                $display("FAIL req_stall%0d got v=%0h a=%h exp 1/80000004",
                         i, mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
            end
        end
        do_fetch(32'h4020_8033, 1'b0);
        checks++;
        if (opcode !== 7'h33 || func3 !== 3'd0 || func7 !== 7'h20 ||
            pc !== 64'h8000_0004) begin
            errors++;
            $display("FAIL seq_inst got %h/%h/%h pc=%h exp 33/0/20/80000004",
                     opcode, func3, func7, pc);
        end
    endtask

    task automatic test_redirect();
        jump = 1'b1;
        dnpc = 64'h8000_0200;
        step();
        step();
        checks++;
        if (pc !== 64'h8000_0004 || inst_valid !== 1'b1 ||
            mem_if.req_valid_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL jump_noret got pc=%h iv=%0h rv=%0h exp 80000004/1/0",
                     pc, inst_valid, mem_if.req_valid_o_ifu);
        end
        do_retire(1'b1, 64'h8000_0100);
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h8000_0100) begin
            errors++;
            $display("FAIL redir_req got v=%0h a=%h exp 1/80000100",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
        end
        do_fetch(32'h0020_c463, 1'b0);
        checks++;
        if (opcode !== 7'h63 || func3 !== 3'd4 || func7 !== 7'd0 ||
            pc !== 64'h8000_0100) begin
            errors++;
            $display("FAIL redir_inst got %h/%h/%h pc=%h exp 63/4/0/80000100",
                     opcode, func3, func7, pc);
        end
    endtask

    task automatic test_hold_stall();
        for (int i = 0; i < 5; i++) begin
            mem_if.rsp_valid_i_ifu = (i == 2);
            mem_if.rsp_data_i_ifu  = 32'hFFFF_FFFF;
            step();
            checks++;
            if (inst_valid !== 1'b1 || inst !== 32'h0020_c463 ||
                pc !== 64'h8000_0100 ||
                mem_if.req_valid_o_ifu !== 1'b0) begin
                errors++;
                $display("FAIL hold%0d got iv=%0h i=%h pc=%h rv=%0h exp 1/0020c463/80000100/0",
                         i, inst_valid, inst, pc, mem_if.req_valid_o_ifu);
            end
        end
        mem_if.rsp_valid_i_ifu = 1'b0;
        do_retire(1'b0, 64'h0);
        checks++;
        if (mem_if.req_addr_o_ifu !== 64'h8000_0104) begin
            errors++;
            $display("FAIL hold_next got a=%h exp 80000104",
                     mem_if.req_addr_o_ifu);
        end
    endtask

    task automatic test_fault();
        do_fetch(32'hDEAD_BEEF, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || fault !== 1'b1 ||
            inst !== 32'hDEAD_BEEF || opcode !== 7'h6F) begin
            errors++;
            $display("FAIL bus_err got iv=%0h f=%0h i=%h op=%h exp 1/1/deadbeef/6f",
                     inst_valid, fault, inst, opcode);
        end
        do_retire(1'b1, 64'h8000_0002);
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL mis_req got rv=%0h iv=%0h exp 0/0",
                     mem_if.req_valid_o_ifu, inst_valid);
        end
        mem_if.req_ready_i_ifu = 1'b1;
        step();
        mem_if.req_ready_i_ifu = 1'b0;
        checks++;
        if (inst_valid !== 1'b1 || fault !== 1'b1 ||
            inst !== 32'h0000_0013 || pc !== 64'h8000_0002 ||
            mem_if.req_valid_o_ifu !== 1'b0) begin
            errors++;
            $display("FAIL mis_hold got iv=%0h f=%0h i=%h pc=%h rv=%0h exp 1/1/00000013/80000002/0",
                     inst_valid, fault, inst, pc, mem_if.req_valid_o_ifu);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1 || fault !== 1'b1) begin
            errors++;
            $display("FAIL mis_sticky got iv=%0h f=%0h exp 1/1",
                     inst_valid, fault);
        end
        do_retire(1'b1, 64'h8000_0008);
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h8000_0008) begin
            errors++;
            $display("FAIL recover_req got v=%0h a=%h exp 1/80000008",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
        end
        do_fetch(32'h0000_0013, 1'b0);
        checks++;
        if (fault !== 1'b0 || pc !== 64'h8000_0008) begin
            errors++;
            $display("FAIL recover_inst got f=%0h pc=%h exp 0/80000008",
                     fault, pc);
        end
    endtask

    task automatic test_reset_in_wait();
        do_retire(1'b0, 64'h0);
        mem_if.req_ready_i_ifu = 1'b1;
        step();
        mem_if.req_ready_i_ifu = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b0 || inst_valid !== 1'b0 ||
            pc !== 64'h8000_0000 || inst !== 32'h0000_0013) begin
            errors++;
            $display("FAIL async_rst got rv=%0h iv=%0h pc=%h i=%h exp 0/0/80000000/00000013",
                     mem_if.req_valid_o_ifu, inst_valid, pc, inst);
        end
        step();
        rst = 1'b1;
        mem_if.rsp_valid_i_ifu = 1'b1;
        mem_if.rsp_data_i_ifu  = 32'h1234_5678;
        #1;
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h8000_0000) begin
            errors++;
            $display("FAIL restart_req got v=%0h a=%h exp 1/80000000",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
        end
        step();
        mem_if.rsp_valid_i_ifu = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || inst !== 32'h0000_0013 ||
            mem_if.req_valid_o_ifu !== 1'b1) begin
            errors++;
            $display("FAIL late_rsp got iv=%0h i=%h rv=%0h exp 0/00000013/1",
                     inst_valid, inst, mem_if.req_valid_o_ifu);
        end
        do_fetch(32'h0050_0093, 1'b0);
        checks++;
        if (inst !== 32'h0050_0093 || pc !== 64'h8000_0000) begin
            errors++;
            $display("FAIL restart_inst got i=%h pc=%h exp 00500093/80000000",
                     inst, pc);
        end
    endtask

    task automatic test_wrap();
        do_retire(1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        checks++;
        if (mem_if.req_addr_o_ifu !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_req got a=%h exp fffffffffffffffc",
                     mem_if.req_addr_o_ifu);
        end
        do_fetch(32'h0000_0013, 1'b0);
        do_retire(1'b0, 64'h0);
        checks++;
        if (mem_if.req_valid_o_ifu !== 1'b1 ||
            mem_if.req_addr_o_ifu !== 64'h0) begin
            errors++;
            $display("FAIL wrap_next got v=%0h a=%h exp 1/0",
                     mem_if.req_valid_o_ifu, mem_if.req_addr_o_ifu);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_seq_stall();
        test_redirect();
        test_hold_stall();
        test_fault();
        test_reset_in_wait();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
